mm_refill_arbiter: RTL and testbench

Shares the single main-memory read port between the instruction-cache and data-cache refill controllers. Each cache controller raises a line-refill request with a line address. The arbiter grants one requester at a time, round-robin, and sequences the whole line burst on main memory. It then steers the returned words back to the owner. It sits between the two cache controllers and the main-memory model, in place of a direct controller-to-memory connection.

---
 rtl/mm_arb_pkg.sv | 12 +
 rtl/mm_refill_arbiter_rr_pick2.sv | 22 ++
 rtl/mm_refill_arbiter.sv | 126 ++++++++++++
 tb/tb_mm_refill_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_arb_pkg.sv
// Shared types and helpers for the main-memory refill arbiter.
// OFF is the bit position of the line index inside a byte address.
package mm_arb_pkg;

   typedef enum logic [1:0] {IDLE, START, BURST} state_t;
   typedef enum logic {IMEM, DMEM} owner_t;

   function automatic int off_bits(input int words_per_line);
      return $clog2(words_per_line) + 2;
   endfunction

endpackage

// File: rtl/mm_refill_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a tie the requester not served last wins.
module rr_pick2
   import mm_arb_pkg::*;
(
   input  logic   req_imem,
   input  logic   req_dmem,
   input  owner_t last_owner,
   output logic   any,
   output owner_t pick
);

   always_comb begin
      any  = req_imem | req_dmem;
      pick = DMEM;
      if (req_imem && req_dmem) begin
         pick = (last_owner == IMEM) ? DMEM : IMEM;
      end else if (req_imem) begin
         pick = IMEM;
      end
   end

endmodule

// File: rtl/mm_refill_arbiter.sv
// Arbitrates I-cache and D-cache line refills onto one main-memory read port,
// sequencing a full aligned line burst and steering returned words to the owner.
module mm_refill_arbiter
   import mm_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int WORDS_PER_LINE = 4
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_imem,
   input  logic [ADDR_WIDTH-1:0] addr_imem,
   input  logic                  req_dmem,
   input  logic [ADDR_WIDTH-1:0] addr_dmem,
   output logic                  gnt_imem,
   output logic                  gnt_dmem,
   output logic                  valid_imem,
   output logic                  valid_dmem,
   output logic                  done_imem,
   output logic                  done_dmem,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  re_mm,
   output logic                  reset_mm,
   output logic [ADDR_WIDTH-1:0] addr_mm,
   input  logic                  mem_valid_mm,
   input  logic [DATA_WIDTH-1:0] rdata_mm
);

   localparam int OFF    = off_bits(WORDS_PER_LINE);
   localparam int BEAT_W = OFF - 2;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

   state_t                   state_reg;
   owner_t                   owner_reg;
   owner_t                   last_owner_reg;
   logic [ADDR_WIDTH-OFF-1:0] line_reg;
   logic [BEAT_W-1:0]        beat_reg;
   logic                     gnt_imem_reg;
   logic                     gnt_dmem_reg;
   logic                     re_mm_reg;
   logic                     reset_mm_reg;

   logic   pick_any;
   owner_t pick_owner;
   logic   in_burst;
   logic   beat_valid;
   logic   last_beat;
   logic   unused_addr_bits;

   // Only the line index of a miss address matters; the word offset is dropped.
   assign unused_addr_bits = ^{addr_imem[OFF-1:0], addr_dmem[OFF-1:0]};

   rr_pick2 u_pick (
      .req_imem   (req_imem),
      .req_dmem   (req_dmem),
      .last_owner (last_owner_reg),
      .any        (pick_any),
      .pick       (pick_owner)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         owner_reg      <= IMEM;
         last_owner_reg <= DMEM;
         line_reg       <= '0;
         beat_reg       <= '0;
         gnt_imem_reg   <= 1'b0;
         gnt_dmem_reg   <= 1'b0;
         re_mm_reg      <= 1'b0;
         reset_mm_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pick_any) begin
                  owner_reg    <= pick_owner;
                  line_reg     <= (pick_owner == IMEM) ? addr_imem[ADDR_WIDTH-1:OFF]
                                                       : addr_dmem[ADDR_WIDTH-1:OFF];
                  beat_reg     <= '0;
                  gnt_imem_reg <= (pick_owner == IMEM);
                  gnt_dmem_reg <= (pick_owner == DMEM);
                  reset_mm_reg <= 1'b1;
                  state_reg    <= START;
               end
            end
            START: begin
               reset_mm_reg <= 1'b0;
               re_mm_reg    <= 1'b1;
               state_reg    <= BURST;
            end
            BURST: begin
               if (mem_valid_mm) begin
                  if (beat_reg == LAST_BEAT) begin
                     last_owner_reg <= owner_reg;
                     gnt_imem_reg   <= 1'b0;
                     gnt_dmem_reg   <= 1'b0;
                     re_mm_reg      <= 1'b0;
                     state_reg      <= IDLE;
                  end else begin
                     beat_reg <= beat_reg + 1'b1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Returned words bypass any register so the owner sees them in the same cycle.
   assign in_burst   = (state_reg == BURST);
   assign beat_valid = in_burst && mem_valid_mm;
   assign last_beat  = (beat_reg == LAST_BEAT);

   assign gnt_imem   = gnt_imem_reg;
   assign gnt_dmem   = gnt_dmem_reg;
   assign re_mm      = re_mm_reg;
   assign reset_mm   = reset_mm_reg;
   assign valid_imem = beat_valid && (owner_reg == IMEM);
   assign valid_dmem = beat_valid && (owner_reg == DMEM);
   assign done_imem  = valid_imem && last_beat;
   assign done_dmem  = valid_dmem && last_beat;
   assign rdata      = beat_valid ? rdata_mm : '0;
   assign addr_mm    = in_burst ? {line_reg, beat_reg, 2'b00} : '0;

endmodule

// File: tb/tb_mm_refill_arbiter.sv
// Randomised bench for mm_refill_arbiter: a transaction-level model predicts
// every output each cycle, and directed scenarios pin the model with literals.
module tb_mm_refill_arbiter;

   localparam int WPL = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_imem = 1'b0, req_dmem = 1'b0;
   logic [31:0] addr_imem = '0, addr_dmem = '0;
   logic        gnt_imem, gnt_dmem, valid_imem, valid_dmem, done_imem, done_dmem;
   logic [31:0] rdata;
   logic        re_mm, reset_mm;
   logic [31:0] addr_mm;
   logic        mem_valid_mm = 1'b0;
   logic [31:0] rdata_mm = '0;

   mm_refill_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WORDS_PER_LINE(WPL)) dut (
      .clk(clk), .reset(reset),
      .req_imem(req_imem), .addr_imem(addr_imem),
      .req_dmem(req_dmem), .addr_dmem(addr_dmem),
      .gnt_imem(gnt_imem), .gnt_dmem(gnt_dmem),
      .valid_imem(valid_imem), .valid_dmem(valid_dmem),
      .done_imem(done_imem), .done_dmem(done_dmem),
      .rdata(rdata), .re_mm(re_mm), .reset_mm(reset_mm), .addr_mm(addr_mm),
      .mem_valid_mm(mem_valid_mm), .rdata_mm(rdata_mm)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural model: a grant is a sequence of cycles counted from its start;
   // cycle 0 restarts memory, later cycles read word (line + 4*words).
   bit          m_known = 0;
   bit          m_busy = 0;
   bit          m_own = 0;      // 0 = IMEM, 1 = DMEM
   bit          m_last = 1;
   int          m_age = 0;
   int          m_words = 0;
   logic [31:0] m_line = '0;
   bit          seen_done_i = 0, seen_done_d = 0;

   typedef struct { bit own; logic [31:0] addr; bit done; int cyc; } beat_t;
   typedef struct { bit own; int cyc; } start_t;
   beat_t  beats[$];
   start_t starts[$];
   int     gnt_d_cnt = 0;

   initial begin : compare_proc
      bit e_gi, e_gd, e_re, e_rst, e_vi, e_vd, e_di, e_dd;
      logic [31:0] e_addr, e_rdata;
      forever begin
         @(negedge clk);
         e_gi    = m_busy && !m_own;
         e_gd    = m_busy && m_own;
         e_rst   = m_busy && (m_age == 0);
         e_re    = m_busy && (m_age > 0);
         e_addr  = e_re ? m_line + 32'(4 * m_words) : 32'h0;
         e_vi    = e_re && mem_valid_mm && !m_own;
         e_vd    = e_re && mem_valid_mm && m_own;
         e_di    = e_vi && (m_words == WPL - 1);
         e_dd    = e_vd && (m_words == WPL - 1);
         e_rdata = (e_vi || e_vd) ? rdata_mm : 32'h0;
         if (m_known) begin
            n_cmp++;
            if ({gnt_imem, gnt_dmem, valid_imem, valid_dmem, done_imem, done_dmem, re_mm, reset_mm} !==
                {e_gi, e_gd, e_vi, e_vd, e_di, e_dd, e_re, e_rst} ||
                addr_mm !== e_addr || rdata !== e_rdata) begin
               n_err++;
               $display("FAIL cycle_check cyc=%0d got gnt=%b%b val=%b%b done=%b%b re=%b rst=%b addr=%h rdata=%h want gnt=%b%b val=%b%b done=%b%b re=%b rst=%b addr=%h rdata=%h",
                        cyc, gnt_imem, gnt_dmem, valid_imem, valid_dmem, done_imem, done_dmem, re_mm, reset_mm, addr_mm, rdata,
                        e_gi, e_gd, e_vi, e_vd, e_di, e_dd, e_re, e_rst, e_addr, e_rdata);
            end
            seen_done_i = e_di;
            seen_done_d = e_dd;
         end
         if (reset_mm === 1'b1) starts.push_back('{own: gnt_dmem, cyc: cyc});
         if (gnt_dmem === 1'b1) gnt_d_cnt++;
         if (valid_imem === 1'b1 || valid_dmem === 1'b1)
            beats.push_back('{own: valid_dmem, addr: addr_mm, done: (done_imem | done_dmem), cyc: cyc});
         if (done_imem === 1'b1 || done_dmem === 1'b1)
            $display("line %s: last word addr=%h data=%h cyc=%0d", done_dmem ? "DMEM" : "IMEM", addr_mm, rdata, cyc);
         // advance the model to the state after the coming clock edge
         if (reset) begin
            m_known = 1; m_busy = 0; m_last = 1; m_age = 0; m_words = 0;
         end else if (m_known) begin
            if (!m_busy) begin
               if (req_imem || req_dmem) begin
                  m_own   = (req_imem && req_dmem) ? !m_last : !req_imem;
                  m_line  = (m_own ? addr_dmem : addr_imem) & ~32'(WPL * 4 - 1);
                  m_busy  = 1; m_age = 0; m_words = 0;
               end
            end else begin
               if (e_re && mem_valid_mm) m_words++;
               m_age++;
               if (m_words == WPL) begin
                  m_busy = 0;
                  m_last = m_own;
               end
            end
         end
      end
   end

   int mv_mode = 0;   // 0 hold, 1 random, 2 toggle

   task automatic step();
      @(posedge clk); #1;
      if (seen_done_i) req_imem = 1'b0;
      if (seen_done_d) req_dmem = 1'b0;
      case (mv_mode)
         1: mem_valid_mm = ($urandom_range(0, 3) != 0);
         2: mem_valid_mm = ~mem_valid_mm;
         default: ;
      endcase
      rdata_mm = $urandom;
   endtask

   task automatic check_int(input string name, input longint got, input longint want);
      n_cmp++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic clear_logs();
      beats.delete(); starts.delete(); gnt_d_cnt = 0;
   endtask

   task automatic reset_dut();
      reset = 1'b1; req_imem = 1'b0; req_dmem = 1'b0;
      repeat (3) step();
      reset = 1'b0;
   endtask

   task automatic wait_done(input bit which, input int limit);
      int k;
      for (k = 0; k < limit; k++) begin
         step();
         if (which ? (req_dmem == 1'b0 && seen_done_d) : (req_imem == 1'b0 && seen_done_i)) break;
      end
      if (k == limit) begin
         n_cmp++; n_err++;
         $display("FAIL wait_done owner=%0d got timeout want done within %0d cycles", which, limit);
      end
   endtask

   task automatic check_line(input string name, input bit own, input logic [31:0] base);
      int n = 0;
      foreach (beats[i]) begin
         if (beats[i].own == own) begin
            check_int({name, "_addr"}, beats[i].addr, base + 32'(4 * n));
            check_int({name, "_done"}, beats[i].done, (n == WPL - 1));
            n++;
         end
      end
      check_int({name, "_words"}, n, WPL);
   endtask

   function automatic int done_cyc(input bit own);
      foreach (beats[i]) if (beats[i].own == own && beats[i].done) return beats[i].cyc;
      return -100;
   endfunction

   initial begin : stim
      int t0;
      int k;
      reset_dut();
      step(); #1;
      check_int("reset_outputs", {gnt_imem, gnt_dmem, re_mm, reset_mm, valid_imem, valid_dmem}, 0);
      check_int("reset_addr", addr_mm, 0);

      // single IMEM line
      clear_logs(); mv_mode = 0; mem_valid_mm = 1'b1;
      step(); t0 = cyc; req_imem = 1'b1; addr_imem = 32'h0000_0104;
      wait_done(0, 40);
      check_int("t1_nstarts", starts.size(), 1);
      if (starts.size() > 0) begin
         check_int("t1_start_cyc", starts[0].cyc, t0 + 1);
         check_int("t1_start_own", starts[0].own, 0);
      end
      check_line("t1", 0, 32'h0000_0100);
      check_int("t1_gnt_dmem", gnt_d_cnt, 0);

      // simultaneous requests: IMEM, then DMEM, then IMEM again
      reset_dut(); clear_logs();
      step(); t0 = cyc; req_imem = 1'b1; addr_imem = 32'h0000_1000; req_dmem = 1'b1; addr_dmem = 32'h0000_2004;
      wait_done(0, 40);
      wait_done(1, 40);
      req_imem = 1'b1; req_dmem = 1'b1;
      wait_done(0, 40);
      check_int("t2_nstarts", starts.size(), 3);
      if (starts.size() >= 3) begin
         check_int("t2_first_own", starts[0].own, 0);
         check_int("t2_first_cyc", starts[0].cyc, t0 + 1);
         check_int("t2_second_own", starts[1].own, 1);
         check_int("t2_second_cyc", starts[1].cyc, done_cyc(0) + 2);
         check_int("t2_third_own", starts[2].own, 0);
      end
      wait_done(1, 40);

      // toggling memory valid
      reset_dut(); clear_logs(); mv_mode = 2;
      step(); req_imem = 1'b1; addr_imem = 32'h0000_ABC8;
      wait_done(0, 60);
      check_line("t3", 0, 32'h0000_ABC0);
      for (int i = 1; i < beats.size(); i++) check_int("t3_spacing", beats[i].cyc - beats[i-1].cyc, 2);

      // reset in the middle of a DMEM burst
      reset_dut(); clear_logs(); mv_mode = 0; mem_valid_mm = 1'b1;
      step(); req_dmem = 1'b1; addr_dmem = 32'h2000_0040;
      for (k = 0; k < 40 && beats.size() < 1; k++) step();
      reset = 1'b1;
      step(); reset = 1'b0; req_dmem = 1'b0; #1;
      check_int("t4_dmem_words", beats.size(), 2);
      check_int("t4_zero_outputs", {gnt_imem, gnt_dmem, re_mm, reset_mm, valid_imem, valid_dmem}, 0);
      check_int("t4_zero_addr", addr_mm, 0);
      clear_logs();
      step(); req_imem = 1'b1; addr_imem = 32'h3000_0010;
      wait_done(0, 40);
      check_line("t4", 0, 32'h3000_0010);

      // owner drops request mid-burst while the other waits
      reset_dut(); clear_logs();
      step(); req_imem = 1'b1; addr_imem = 32'h0000_0500; req_dmem = 1'b1; addr_dmem = 32'h0000_0600;
      for (k = 0; k < 40 && beats.size() < 2; k++) step();
      req_imem = 1'b0;
      for (k = 0; k < 40 && done_cyc(0) < 0; k++) step();
      wait_done(1, 40);
      check_line("t5_imem", 0, 32'h0000_0500);
      if (starts.size() >= 2) check_int("t5_second_own", starts[1].own, 1);
      else check_int("t5_nstarts", starts.size(), 2);

      // memory valid while idle
      reset_dut(); mv_mode = 0; mem_valid_mm = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(); #1;
         check_int("t6_idle_valid", {valid_imem, valid_dmem}, 0);
         check_int("t6_idle_rdata", rdata, 0);
      end

      // random traffic
      mv_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (!req_imem && $urandom_range(0, 5) == 0) begin req_imem = 1'b1; addr_imem = $urandom; end
         if (!req_dmem && $urandom_range(0, 5) == 0) begin req_dmem = 1'b1; addr_dmem = $urandom; end
         reset = ($urandom_range(0, 799) == 0);
      end
      reset = 1'b0;
      step(); step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
